// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks E/M/W destinations and Tnew, produces stall
// and forwarding selects, and interlocks HI/LO readers against the mult/div unit.
module hazard_scoreboard #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_addr_D,
   input  logic [4:0] rt_addr_D,
   input  logic [1:0] rs_tuse,
   input  logic [1:0] rt_tuse,
   input  logic [4:0] dst_D,
   input  logic [1:0] tnew_D,
   input  logic       md_start_D,
   input  logic       md_is_div_D,
   input  logic       use_md_D,
   output logic       stall,
   output logic [1:0] fwd_rs_D,
   output logic [1:0] fwd_rt_D,
   output logic [1:0] fwd_rs_E,
   output logic [1:0] fwd_rt_E,
   output logic       fwd_rt_M
);

   localparam int unsigned AW = 5;
   localparam int unsigned TW = 2;
   localparam int unsigned CW = 4;

   logic [AW-1:0] e_dst, e_rs, e_rt;
   logic [TW-1:0] e_tnew;
   logic [AW-1:0] m_dst, m_rt;
   logic [TW-1:0] m_tnew;
   logic [AW-1:0] w_dst;
   logic [CW-1:0] md_cnt;

   logic rs_stall, rt_stall, md_stall;

   // A producer in E or M whose result arrives later than the consumer needs it.
   function automatic logic data_stall(input logic [AW-1:0] addr, input logic [TW-1:0] tuse,
                                       input logic [AW-1:0] ed, input logic [TW-1:0] et,
                                       input logic [AW-1:0] md, input logic [TW-1:0] mt);
      logic hit;
      hit = 1'b0;
      if (addr != '0) begin
         if (ed == addr && et > tuse) hit = 1'b1;
         if (md == addr && mt > tuse) hit = 1'b1;
      end
      return hit;
   endfunction

   // Nearest matching stage wins; a not-yet-ready nearest match blocks older stages.
   function automatic logic [1:0] fwd_d_sel(input logic [AW-1:0] addr,
                                            input logic [AW-1:0] ed, input logic [TW-1:0] et,
                                            input logic [AW-1:0] md, input logic [TW-1:0] mt,
                                            input logic [AW-1:0] wd);
      logic [1:0] sel;
      sel = 2'd0;
      if (addr != '0) begin
         if (ed == addr)      sel = (et == '0) ? 2'd1 : 2'd0;
         else if (md == addr) sel = (mt == '0) ? 2'd2 : 2'd0;
         else if (wd == addr) sel = 2'd3;
      end
      return sel;
   endfunction

   function automatic logic [1:0] fwd_e_sel(input logic [AW-1:0] addr,
                                            input logic [AW-1:0] md, input logic [TW-1:0] mt,
                                            input logic [AW-1:0] wd);
      logic [1:0] sel;
      sel = 2'd0;
      if (addr != '0) begin
         if (md == addr && mt == '0) sel = 2'd1;
         else if (wd == addr)        sel = 2'd2;
      end
      return sel;
   endfunction

   always_comb begin
      rs_stall = data_stall(rs_addr_D, rs_tuse, e_dst, e_tnew, m_dst, m_tnew);
      rt_stall = data_stall(rt_addr_D, rt_tuse, e_dst, e_tnew, m_dst, m_tnew);
      md_stall = use_md_D && (md_cnt != '0);
      stall    = rs_stall || rt_stall || md_stall;
      fwd_rs_D = fwd_d_sel(rs_addr_D, e_dst, e_tnew, m_dst, m_tnew, w_dst);
      fwd_rt_D = fwd_d_sel(rt_addr_D, e_dst, e_tnew, m_dst, m_tnew, w_dst);
      fwd_rs_E = fwd_e_sel(e_rs, m_dst, m_tnew, w_dst);
      fwd_rt_E = fwd_e_sel(e_rt, m_dst, m_tnew, w_dst);
      fwd_rt_M = (m_rt != '0) && (m_rt == w_dst);
   end

   // Pipeline tracking and HI/LO busy counter; a stall turns E into a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_dst  <= '0;
         e_rs   <= '0;
         e_rt   <= '0;
         e_tnew <= '0;
         m_dst  <= '0;
         m_rt   <= '0;
         m_tnew <= '0;
         w_dst  <= '0;
         md_cnt <= '0;
      end else begin
         m_dst  <= e_dst;
         m_rt   <= e_rt;
         m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
         w_dst  <= m_dst;
         if (stall) begin
            e_dst  <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            e_tnew <= '0;
         end else begin
            e_dst  <= dst_D;
            e_rs   <= rs_addr_D;
            e_rt   <= rt_addr_D;
            e_tnew <= tnew_D;
         end
         if (md_start_D && !stall)
            md_cnt <= md_is_div_D ? CW'(DIV_LAT) : CW'(MULT_LAT);
         else if (md_cnt != '0)
            md_cnt <= md_cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: classic MIPS hazard pairs and HI/LO interlocks.
module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic [4:0] rs_addr_D, rt_addr_D, dst_D;
   logic [1:0] rs_tuse, rt_tuse, tnew_D;
   logic       md_start_D, md_is_div_D, use_md_D;
   logic       stall;
   logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
   logic       fwd_rt_M;

   int checks;
   int failures;
   int n;

   hazard_scoreboard #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .rs_addr_D  (rs_addr_D),
      .rt_addr_D  (rt_addr_D),
      .rs_tuse    (rs_tuse),
      .rt_tuse    (rt_tuse),
      .dst_D      (dst_D),
      .tnew_D     (tnew_D),
      .md_start_D (md_start_D),
      .md_is_div_D(md_is_div_D),
      .use_md_D   (use_md_D),
      .stall      (stall),
      .fwd_rs_D   (fwd_rs_D),
      .fwd_rt_D   (fwd_rt_D),
      .fwd_rs_E   (fwd_rs_E),
      .fwd_rt_E   (fwd_rt_E),
      .fwd_rt_M   (fwd_rt_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_d(input int rs, input int rt, input int rsu, input int rtu,
                        input int dst, input int tn, input int mds, input int mdd, input int umd);
      rs_addr_D   = 5'(rs);
      rt_addr_D   = 5'(rt);
      rs_tuse     = 2'(rsu);
      rt_tuse     = 2'(rtu);
      dst_D       = 5'(dst);
      tnew_D      = 2'(tn);
      md_start_D  = 1'(mds);
      md_is_div_D = 1'(mdd);
      use_md_D    = 1'(umd);
   endtask

   task automatic nop();
      set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   // Count consecutive stall cycles for the instruction currently held in D.
   task automatic count_stalls(output int cnt);
      cnt = 0;
      @(negedge clk);
      while (stall && cnt < 40) begin
         cnt++;
         tick();
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      set_d(2, 2, 0, 0, 0, 0, 0, 0, 1);
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_stall", int'(stall), 0);
      check("rst_fwd_rs_D", int'(fwd_rs_D), 0);
      check("rst_fwd_rs_E", int'(fwd_rs_E), 0);
      check("rst_fwd_rt_M", int'(fwd_rt_M), 0);
      flush();

      // lw $2 ; add $3,$2,$4
      set_d(0, 0, 3, 3, 2, 2, 0, 0, 0);
      @(negedge clk);
      check("lw_add_issue", int'(stall), 0);
      tick();
      set_d(2, 4, 1, 1, 3, 1, 0, 0, 0);
      @(negedge clk);
      check("lw_add_stall", int'(stall), 1);
      tick();
      @(negedge clk);
      check("lw_add_release", int'(stall), 0);
      tick();
      nop();
      @(negedge clk);
      check("lw_add_fwd_rs_E", int'(fwd_rs_E), 2);
      check("lw_add_fwd_rt_E", int'(fwd_rt_E), 0);
      flush();

      // lw $2 ; beq $2,$0
      set_d(0, 0, 3, 3, 2, 2, 0, 0, 0);
      tick();
      set_d(2, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("lw_beq_stall1", int'(stall), 1);
      tick();
      @(negedge clk);
      check("lw_beq_stall2", int'(stall), 1);
      check("lw_beq_blocked", int'(fwd_rs_D), 0);
      tick();
      @(negedge clk);
      check("lw_beq_release", int'(stall), 0);
      check("lw_beq_fwd_rs_D", int'(fwd_rs_D), 3);
      check("lw_beq_fwd_rt_D", int'(fwd_rt_D), 0);
      flush();

      // add $5 ; beq $5,$6
      set_d(0, 0, 3, 3, 5, 1, 0, 0, 0);
      tick();
      set_d(5, 6, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("add_beq_stall", int'(stall), 1);
      tick();
      @(negedge clk);
      check("add_beq_release", int'(stall), 0);
      check("add_beq_fwd_rs_D", int'(fwd_rs_D), 2);
      check("add_beq_fwd_rt_D", int'(fwd_rt_D), 0);
      flush();

      // jal ; jr $31
      set_d(0, 0, 3, 3, 31, 0, 0, 0, 0);
      tick();
      set_d(31, 0, 0, 3, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("jal_jr_stall", int'(stall), 0);
      check("jal_jr_fwd_rs_D", int'(fwd_rs_D), 1);
      flush();

      // ori $0 ; add reading $0 : register 0 never matches
      set_d(0, 0, 3, 3, 0, 1, 0, 0, 0);
      tick();
      set_d(0, 0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      check("zero_stall", int'(stall), 0);
      check("zero_fwd_rs_D", int'(fwd_rs_D), 0);
      check("zero_fwd_rt_D", int'(fwd_rt_D), 0);
      tick();
      nop();
      @(negedge clk);
      check("zero_fwd_rs_E", int'(fwd_rs_E), 0);
      check("zero_fwd_rt_E", int'(fwd_rt_E), 0);
      tick();
      @(negedge clk);
      check("zero_fwd_rt_M", int'(fwd_rt_M), 0);
      flush();

      // lw $7 ; sw $7 : store data forwarded from W into M
      set_d(0, 0, 3, 3, 7, 2, 0, 0, 0);
      tick();
      set_d(0, 7, 3, 2, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("lw_sw_stall", int'(stall), 0);
      tick();
      nop();
      @(negedge clk);
      check("lw_sw_fwd_rt_E", int'(fwd_rt_E), 0);
      tick();
      @(negedge clk);
      check("lw_sw_fwd_rt_M", int'(fwd_rt_M), 1);
      flush();

      // mult ; mflo
      set_d(0, 0, 3, 3, 0, 0, 1, 0, 1);
      @(negedge clk);
      check("mult_issue", int'(stall), 0);
      tick();
      set_d(0, 0, 3, 3, 8, 1, 0, 0, 1);
      count_stalls(n);
      check("mult_mflo_cycles", n, 5);
      tick();
      flush();

      // mult ; div (busy) ; mfhi
      set_d(0, 0, 3, 3, 0, 0, 1, 0, 1);
      tick();
      set_d(0, 0, 3, 3, 0, 0, 1, 1, 1);
      count_stalls(n);
      check("mult_div_cycles", n, 5);
      tick();
      set_d(0, 0, 3, 3, 9, 1, 0, 0, 1);
      count_stalls(n);
      check("div_mfhi_cycles", n, 10);
      tick();
      flush();

      // lw $9 ; mult $9 : data-stalled issue must not load the counter
      set_d(0, 0, 3, 3, 9, 2, 0, 0, 0);
      tick();
      set_d(9, 0, 1, 3, 0, 0, 1, 0, 1);
      @(negedge clk);
      check("mult_data_stall", int'(stall), 1);
      tick();
      @(negedge clk);
      check("mult_data_release", int'(stall), 0);
      tick();
      set_d(0, 0, 3, 3, 8, 1, 0, 0, 1);
      count_stalls(n);
      check("stalled_mult_cycles", n, 5);
      tick();
      flush();

      // div ; mfhi with reset mid-busy
      set_d(0, 0, 3, 3, 0, 0, 1, 1, 1);
      tick();
      set_d(0, 0, 3, 3, 9, 1, 0, 0, 1);
      @(negedge clk);
      check("div_busy1", int'(stall), 1);
      tick();
      @(negedge clk);
      check("div_busy2", int'(stall), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("div_reset_stall", int'(stall), 0);
      check("div_reset_fwd_rs_E", int'(fwd_rs_E), 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
